// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1) with a configurable rx synchronizer chain.
// Define UART_RX_MAJORITY_EN to make each bit decision a 2-of-3 vote over the last three ticks.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       b_tick,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   sample;
  logic [1:0]             state;
  logic [3:0]             tick_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // hist holds the rx_s values from the two previous ticks; rx_s itself is the third vote.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b11;
    end else if (state == IDLE && !rx_s) begin
      hist <= 2'b11;
    end else if (b_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= 4'd0;
            rx_busy  <= 1'b1;
          end
        end
        START: begin
          if (b_tick) begin
            if (tick_cnt == 4'd7) begin
              if (!sample) begin
                state    <= DATA;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (b_tick) begin
            if (tick_cnt == 4'd15) begin
              shift    <= {sample, shift[7:1]};
              tick_cnt <= 4'd0;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a start bit that follows immediately be caught.
          if (b_tick) begin
            if (tick_cnt == 4'd15) begin
              if (sample) begin
                rx_data <= shift;
                rx_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames checked against a frame-level model of the receiver.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       b_tick = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int passed = 0;
  int total = 0;
  int tick_ph = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_done = 0;
  int exp_err = 0;
  bit both_seen = 1'b0;
  bit busy_seen = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] done_q[$];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .b_tick    (b_tick),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  initial forever #5 clk = ~clk;

  // One b_tick per 10 clk.
  initial forever begin
    @(posedge clk);
    #1;
    tick_ph = (tick_ph == 9) ? 0 : tick_ph + 1;
    b_tick = (tick_ph == 9);
  end

  initial forever begin
    @(negedge clk);
    if (rx_done) begin
      done_cnt++;
      done_q.push_back(rx_data);
    end
    if (frame_err) err_cnt++;
    if (rx_done && frame_err) both_seen = 1'b1;
    if (rx_busy) busy_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rx_busy && n < 2000) begin
      wait_clk(1);
      n++;
    end
    check("idle_timeout", {31'd0, rx_busy}, 32'd0);
  endtask

  // glitch_bit: invert that bit for 10 clk around its final sample; rst_bit: reset mid-bit and abort.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int glitch_bit, input int rst_bit);
    rx = 1'b0;
    wait_clk(160);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == rst_bit) begin
        wait_clk(80);
        rst = 1'b1;
        rx = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("rst_mid_data", {8'd0, rx_data}, 32'd0);
        check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_mid_done", {31'd0, rx_done}, 32'd0);
        check("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
        return;
      end
      if (i == glitch_bit) begin
        wait_clk(76);
        rx = ~d[i];
        wait_clk(10);
        rx = d[i];
        wait_clk(74);
      end else begin
        wait_clk(160);
      end
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_clk(160);
    end else begin
      rx = 1'b0;
      wait_clk(100);
      rx = 1'b1;
      wait_clk(60);
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         ok;
    int         n;
    int         err0;

    wait_clk(4);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    check("reset_done", {31'd0, rx_done}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    wait_clk(50);

    send_frame(8'h55, 1'b1, -1, -1);
    exp_done++; exp_data = 8'h55;
    wait_clk(20);
    check("f55_done", done_cnt, exp_done);
    check("f55_ferr", err_cnt, exp_err);
    check("f55_data", {24'd0, rx_data}, {24'd0, exp_data});
    check("f55_busy", {31'd0, rx_busy}, 32'd0);

    busy_seen = 1'b0;
    rx = 1'b0;
    wait_clk(48);
    rx = 1'b1;
    wait_clk(100);
    check("false_start_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("false_start_busy_low", {31'd0, rx_busy}, 32'd0);
    check("false_start_done", done_cnt, exp_done);
    check("false_start_ferr", err_cnt, exp_err);
    check("false_start_data", {24'd0, rx_data}, {24'd0, exp_data});

    send_frame(8'hFF, 1'b0, -1, -1);
    exp_err++;
    wait_idle();
    check("badstop_ferr", err_cnt, exp_err);
    check("badstop_done", done_cnt, exp_done);
    check("badstop_data", {24'd0, rx_data}, 32'h55);

    wait_clk(100);
    done_q.delete();
    send_frame(8'hA5, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, -1, -1);
    exp_done += 2; exp_data = 8'h3C;
    wait_clk(20);
    check("b2b_done", done_cnt, exp_done);
    check("b2b_first", (done_q.size() > 0) ? {24'd0, done_q[0]} : 32'hDEAD, 32'hA5);
    check("b2b_second", (done_q.size() > 1) ? {24'd0, done_q[1]} : 32'hDEAD, 32'h3C);

    send_frame(8'h00, 1'b1, -1, 3);
    exp_data = 8'h00;
    wait_clk(400);
    check("rst_no_done", done_cnt, exp_done);
    send_frame(8'h81, 1'b1, -1, -1);
    exp_done++; exp_data = 8'h81;
    wait_clk(20);
    check("f81_done", done_cnt, exp_done);
    check("f81_data", {24'd0, rx_data}, {24'd0, exp_data});

    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(d, ok, -1, -1);
      if (ok) begin
        exp_done++;
        exp_data = d;
      end else begin
        exp_err++;
      end
      wait_idle();
      check("rand_counts", done_cnt * 256 + err_cnt, exp_done * 256 + exp_err);
      check("rand_data", {24'd0, rx_data}, {24'd0, exp_data});
      if (ok) wait_clk($urandom_range(0, 40));
      else wait_clk(200 + $urandom_range(0, 40));
    end

    err0 = err_cnt;
    rx = 1'b0;
    n = 0;
    while ((err_cnt - err0) < 3 && n < 8000) begin
      wait_clk(1);
      n++;
    end
    wait_clk(10);
    rx = 1'b1;
    exp_err += 3;
    check("break_ferr", err_cnt, exp_err);
    wait_clk(200);
    wait_idle();
    check("break_done", done_cnt, exp_done);
    check("break_data", {24'd0, rx_data}, {24'd0, exp_data});

    wait_clk(50);
    while (tick_ph != 7) wait_clk(1);
    send_frame(8'h0F, 1'b1, 1, -1);
    exp_done++;
`ifdef UART_RX_MAJORITY_EN
    exp_data = 8'h0F;
`else
    exp_data = 8'h0D;
`endif
    wait_clk(20);
    check("glitch_done", done_cnt, exp_done);
    check("glitch_data", {24'd0, rx_data}, {24'd0, exp_data});
    check("done_ferr_exclusive", {31'd0, both_seen}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
